// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Operands enter on a valid/ready handshake; the result leaves on another.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_d_q, sh_d_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;

    logic             x_bit, y_bit, d_bit, br_next;

    assign x_bit   = sh_a_q[0];
    assign y_bit   = sh_b_q[0];
    assign d_bit   = x_bit ^ y_bit ^ borrow_q;
    assign br_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);

    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sh_d_d   = sh_d_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        borrow_d = borrow_q;
        bitcnt_d = bitcnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_a_d   = a;
                    sh_b_d   = b;
                    sh_d_d   = '0;
                    borrow_d = 1'b0;
                    bitcnt_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
                sh_d_d   = {d_bit, sh_d_q[WIDTH-1:1]};
                borrow_d = br_next;
                bitcnt_d = bitcnt_q + CW'(1);
                // Last bit: capture the result including this cycle's difference bit
                if (bitcnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {d_bit, sh_d_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_d_q   <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            borrow_q <= 1'b0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sh_d_q   <= sh_d_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            borrow_q <= borrow_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule
